// File: rtl/gelato_inst_buffer_pkg.sv
// Shared types for the instruction buffer: payload entry layout and
// default sizing of the per-warp FIFOs.
package gelato_types;

  localparam int NUM_WARPS_DEFAULT    = 4;
  localparam int IBUF_DEPTH_DEFAULT   = 4;
  localparam int IBUF_RESERVE_DEFAULT = 2;
  localparam int NUM_THREADS          = 8;

  typedef logic [31:0] inst_t;

  // One buffered instruction; the warp number is implied by which FIFO holds it.
  typedef struct packed {
    logic [31:0]            pc;
    logic [NUM_THREADS-1:0] thread_mask;
    inst_t                  inst;
  } gelato_ibuffer_entry_t;

endpackage

// File: rtl/gelato_stage_if.sv
// Pipeline stage interfaces: decode -> instruction buffer, and
// instruction buffer -> issue.
interface gelato_idecode_ibuffer_if #(
  parameter int NUM_WARPS = gelato_types::NUM_WARPS_DEFAULT
);
  logic                                 valid;
  logic [31:0]                          pc;
  logic [$clog2(NUM_WARPS)-1:0]         warp_num;
  logic [gelato_types::NUM_THREADS-1:0] thread_mask;
  gelato_types::inst_t                  inst;

  modport master (output valid, pc, warp_num, thread_mask, inst);
  modport slave  (input  valid, pc, warp_num, thread_mask, inst);
endinterface

interface gelato_ibuffer_issue_if #(
  parameter int NUM_WARPS = gelato_types::NUM_WARPS_DEFAULT
);
  logic                                 valid;
  logic                                 ready;
  logic [31:0]                          pc;
  logic [$clog2(NUM_WARPS)-1:0]         warp_num;
  logic [gelato_types::NUM_THREADS-1:0] thread_mask;
  gelato_types::inst_t                  inst;

  modport master (output valid, pc, warp_num, thread_mask, inst, input ready);
  modport slave  (input  valid, pc, warp_num, thread_mask, inst, output ready);
endinterface

// File: rtl/gelato_warp_fifo.sv
// Single-warp instruction FIFO. Push and pop may occur together even when
// full (the slot being vacated is the one written). Flush empties it and
// wins over push/pop. Storage is not reset; only pointers and count are.
module gelato_warp_fifo import gelato_types::*; #(
  parameter int DEPTH = IBUF_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  gelato_ibuffer_entry_t        wr_entry,
  output gelato_ibuffer_entry_t        head_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  gelato_ibuffer_entry_t mem_r [DEPTH];
  logic [PW-1:0]         rd_ptr_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [CW-1:0]         count_r;

  // Entry storage: captured on push at the write pointer.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= wr_entry;
    end
  end

  // Pointer and occupancy tracking; flush returns the FIFO to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else if (flush) begin
      rd_ptr_r <= PW'(0);
      wr_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_entry = mem_r[rd_ptr_r];
  assign count      = count_r;
  assign empty      = (count_r == CW'(0));

endmodule

// File: rtl/gelato_inst_buffer.sv
// Per-warp instruction buffer between decode and issue. Holds one FIFO per
// warp, offers one instruction per cycle chosen round-robin over non-empty
// warps, raises per-warp fetch back-pressure, and discards wrong-path
// instructions of a redirected warp.
module gelato_inst_buffer import gelato_types::*; #(
  parameter int NUM_WARPS = NUM_WARPS_DEFAULT,
  parameter int DEPTH     = IBUF_DEPTH_DEFAULT,
  parameter int RESERVE   = IBUF_RESERVE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  gelato_idecode_ibuffer_if.slave      inst_decoded_data,
  gelato_ibuffer_issue_if.master       issue_data,
  input  logic                         flush_valid,
  input  logic [$clog2(NUM_WARPS)-1:0] flush_warp,
  output logic [NUM_WARPS-1:0]         warp_stall,
  output logic                         overflow
);

  localparam int WW = $clog2(NUM_WARPS);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - RESERVE);
  localparam logic [WW-1:0] LAST_WARP = WW'(NUM_WARPS - 1);

  gelato_ibuffer_entry_t wr_entry_s;
  gelato_ibuffer_entry_t head_s  [NUM_WARPS];
  logic [CW-1:0]         count_s [NUM_WARPS];
  logic [NUM_WARPS-1:0]  empty_s;
  logic [NUM_WARPS-1:0]  wr_hit_s;
  logic [NUM_WARPS-1:0]  push_s;
  logic [NUM_WARPS-1:0]  pop_s;
  logic [NUM_WARPS-1:0]  flush_s;
  logic [NUM_WARPS-1:0]  drop_s;
  logic [WW-1:0]         rr_ptr_r;
  logic [WW-1:0]         sel_warp_s;
  logic                  sel_found_s;
  logic                  issue_valid_s;
  logic                  issue_fire_s;
  logic                  overflow_r;

  assign wr_entry_s = '{pc:          inst_decoded_data.pc,
                        thread_mask: inst_decoded_data.thread_mask,
                        inst:        inst_decoded_data.inst};

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
    gelato_warp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_s[w]),
      .pop        (pop_s[w]),
      .flush      (flush_s[w]),
      .wr_entry   (wr_entry_s),
      .head_entry (head_s[w]),
      .count      (count_s[w]),
      .empty      (empty_s[w])
    );
  end

  // Round-robin pick: first non-empty warp at or after rr_ptr (lowest offset wins).
  always_comb begin
    sel_found_s = 1'b0;
    sel_warp_s  = rr_ptr_r;
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      if (!empty_s[(int'(rr_ptr_r) + k) % NUM_WARPS]) begin
        sel_found_s = 1'b1;
        sel_warp_s  = WW'((int'(rr_ptr_r) + k) % NUM_WARPS);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Issue handshake; a warp being redirected this cycle must not issue.
  always_comb begin
    issue_valid_s = rdy && sel_found_s && !(flush_valid && (flush_warp == sel_warp_s));
    issue_fire_s  = issue_valid_s && issue_data.ready;
  end

  // Per-warp steering: flush beats write and issue; a write to a full warp
  // only lands if that warp issues in the same cycle, otherwise it is dropped.
  always_comb begin
    wr_hit_s = '0;
    flush_s  = '0;
    pop_s    = '0;
    push_s   = '0;
    drop_s   = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      wr_hit_s[w] = rdy && inst_decoded_data.valid && (inst_decoded_data.warp_num == WW'(w));
      flush_s[w]  = rdy && flush_valid && (flush_warp == WW'(w));
      pop_s[w]    = issue_fire_s && (sel_warp_s == WW'(w));
      if (wr_hit_s[w] && !flush_s[w]) begin
        if ((count_s[w] != FULL_CNT) || pop_s[w]) begin
          push_s[w] = 1'b1;
        end else begin
          drop_s[w] = 1'b1;
        end
      end else begin
        push_s[w] = 1'b0;
      end
    end
  end

  // Issue payload is the head entry of the selected warp.
  always_comb begin
    issue_data.valid       = issue_valid_s;
    issue_data.warp_num    = sel_warp_s;
    issue_data.pc          = head_s[sel_warp_s].pc;
    issue_data.thread_mask = head_s[sel_warp_s].thread_mask;
    issue_data.inst        = head_s[sel_warp_s].inst;
  end

  // Fetch back-pressure once occupancy eats into the in-flight reserve.
  always_comb begin
    warp_stall = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_stall[w] = (count_s[w] >= STALL_CNT);
    end
  end

  // Round-robin pointer advances past the issued warp; sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r   <= WW'(0);
      overflow_r <= 1'b0;
    end else begin
      if (issue_fire_s) begin
        rr_ptr_r <= (sel_warp_s == LAST_WARP) ? WW'(0) : sel_warp_s + WW'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      if (|drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign overflow = overflow_r;

endmodule

// File: tb/tb_gelato_inst_buffer.sv
// Directed bench for gelato_inst_buffer (4 warps, depth 4, reserve 2).
module tb_gelato_inst_buffer;
  import gelato_types::*;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic       flush_valid;
  logic [1:0] flush_warp;
  logic [3:0] warp_stall;
  logic       overflow;

  gelato_idecode_ibuffer_if #(.NUM_WARPS(4)) dec_if ();
  gelato_ibuffer_issue_if   #(.NUM_WARPS(4)) iss_if ();

  gelato_inst_buffer #(.NUM_WARPS(4), .DEPTH(4), .RESERVE(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .inst_decoded_data (dec_if),
    .issue_data        (iss_if),
    .flush_valid       (flush_valid),
    .flush_warp        (flush_warp),
    .warp_stall        (warp_stall),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;   // rdy
    logic        wv;   // decode valid
    logic [1:0]  ww;   // decode warp
    logic [31:0] wpc;  // decode pc
    logic        rd;   // issue ready
    logic        fv;   // flush valid
    logic [1:0]  fw;   // flush warp
    logic        ev;   // expected issue valid
    logic [1:0]  ew;   // expected issue warp
    logic [31:0] epc;  // expected issue pc
    logic [3:0]  es;   // expected warp_stall
    logic        eo;   // expected overflow
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [7:0] mask_of(input logic [31:0] pc);
    return pc[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic add(input logic en, input logic wv, input logic [1:0] ww, input logic [31:0] wpc,
                     input logic rd, input logic fv, input logic [1:0] fw,
                     input logic ev, input logic [1:0] ew, input logic [31:0] epc,
                     input logic [3:0] es, input logic eo);
    vec_t v;
    v = '{en, wv, ww, wpc, rd, fv, fw, ev, ew, epc, es, eo};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic wv, input logic [1:0] ww, input logic [31:0] wpc,
                       input logic rd, input logic fv, input logic [1:0] fw);
    rdy                = en;
    dec_if.valid       = wv;
    dec_if.warp_num    = ww;
    dec_if.pc          = wpc;
    dec_if.thread_mask = mask_of(wpc);
    dec_if.inst        = inst_of(wpc);
    iss_if.ready       = rd;
    flush_valid        = fv;
    flush_warp         = fw;
  endtask

  task automatic chk_idle(input string tag, input logic eo);
    chk({tag, " valid"}, {31'd0, iss_if.valid}, 32'd0);
    chk({tag, " stall"}, {28'd0, warp_stall}, 32'd0);
    chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, eo});
  endtask

  initial begin
    rst = 1'b1;
    drive(Y, N, 2'd0, 32'h0, N, N, 2'd0);

    // round-robin over warps 0,1,3 with issue held off, then drained
    add(Y,Y,2'd0,32'h1000,N,N,2'd0, N,2'd0,32'h0,   4'b0000,N);
    add(Y,Y,2'd0,32'h1004,N,N,2'd0, Y,2'd0,32'h1000,4'b0000,N);
    add(Y,Y,2'd0,32'h1008,N,N,2'd0, Y,2'd0,32'h1000,4'b0001,N);
    add(Y,Y,2'd0,32'h100C,N,N,2'd0, Y,2'd0,32'h1000,4'b0001,N);
    add(Y,Y,2'd1,32'h2000,N,N,2'd0, Y,2'd0,32'h1000,4'b0001,N);
    add(Y,Y,2'd1,32'h2004,N,N,2'd0, Y,2'd0,32'h1000,4'b0001,N);
    add(Y,Y,2'd1,32'h2008,N,N,2'd0, Y,2'd0,32'h1000,4'b0011,N);
    add(Y,Y,2'd1,32'h200C,N,N,2'd0, Y,2'd0,32'h1000,4'b0011,N);
    add(Y,Y,2'd3,32'h4000,N,N,2'd0, Y,2'd0,32'h1000,4'b0011,N);
    add(Y,Y,2'd3,32'h4004,N,N,2'd0, Y,2'd0,32'h1000,4'b0011,N);
    add(Y,Y,2'd3,32'h4008,N,N,2'd0, Y,2'd0,32'h1000,4'b1011,N);
    add(Y,Y,2'd3,32'h400C,N,N,2'd0, Y,2'd0,32'h1000,4'b1011,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd0,32'h1000,4'b1011,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd1,32'h2000,4'b1011,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd3,32'h4000,4'b1011,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd0,32'h1004,4'b1011,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd1,32'h2004,4'b1011,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd3,32'h4004,4'b1011,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd0,32'h1008,4'b1011,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd1,32'h2008,4'b1010,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd3,32'h4008,4'b1000,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd0,32'h100C,4'b0000,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd1,32'h200C,4'b0000,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, Y,2'd3,32'h400C,4'b0000,N);
    add(Y,N,2'd0,32'h0,Y,N,2'd0, N,2'd0,32'h0,   4'b0000,N);
    // single write to warp 2, visible one cycle later, then drained
    add(Y,Y,2'd2,32'h100,Y,N,2'd0, N,2'd0,32'h0,  4'b0000,N);
    add(Y,N,2'd0,32'h0,  Y,N,2'd0, Y,2'd2,32'h100,4'b0000,N);
    add(Y,N,2'd0,32'h0,  Y,N,2'd0, N,2'd0,32'h0,  4'b0000,N);
    // fill warp 1, write+issue while full, then overflow on a dropped write
    add(Y,Y,2'd1,32'h5000,N,N,2'd0, N,2'd0,32'h0,   4'b0000,N);
    add(Y,Y,2'd1,32'h5004,N,N,2'd0, Y,2'd1,32'h5000,4'b0000,N);
    add(Y,Y,2'd1,32'h5008,N,N,2'd0, Y,2'd1,32'h5000,4'b0010,N);
    add(Y,Y,2'd1,32'h500C,N,N,2'd0, Y,2'd1,32'h5000,4'b0010,N);
    add(Y,Y,2'd1,32'h5010,Y,N,2'd0, Y,2'd1,32'h5000,4'b0010,N);
    add(Y,N,2'd0,32'h0,   N,N,2'd0, Y,2'd1,32'h5004,4'b0010,N);
    add(Y,Y,2'd1,32'h5014,N,N,2'd0, Y,2'd1,32'h5004,4'b0010,N);
    add(Y,N,2'd0,32'h0,   N,N,2'd0, Y,2'd1,32'h5004,4'b0010,Y);
    add(Y,N,2'd0,32'h0,   Y,N,2'd0, Y,2'd1,32'h5004,4'b0010,Y);
    add(Y,N,2'd0,32'h0,   Y,N,2'd0, Y,2'd1,32'h5008,4'b0010,Y);
    add(Y,N,2'd0,32'h0,   Y,N,2'd0, Y,2'd1,32'h500C,4'b0010,Y);
    add(Y,N,2'd0,32'h0,   Y,N,2'd0, Y,2'd1,32'h5010,4'b0000,Y);
    add(Y,N,2'd0,32'h0,   Y,N,2'd0, N,2'd0,32'h0,   4'b0000,Y);
    // flush of the selected warp together with a write to it
    add(Y,Y,2'd0,32'h6000,N,N,2'd0, N,2'd0,32'h0,   4'b0000,Y);
    add(Y,Y,2'd0,32'h6004,N,N,2'd0, Y,2'd0,32'h6000,4'b0000,Y);
    add(Y,Y,2'd0,32'h6008,N,N,2'd0, Y,2'd0,32'h6000,4'b0001,Y);
    add(Y,Y,2'd0,32'h600C,Y,Y,2'd0, N,2'd0,32'h0,   4'b0001,Y);
    add(Y,N,2'd0,32'h0,   Y,N,2'd0, N,2'd0,32'h0,   4'b0000,Y);
    // flush of a non-selected warp leaves issue untouched
    add(Y,Y,2'd2,32'h7000,N,N,2'd0, N,2'd0,32'h0,   4'b0000,Y);
    add(Y,Y,2'd3,32'h7100,N,N,2'd0, Y,2'd2,32'h7000,4'b0000,Y);
    add(Y,N,2'd0,32'h0,   Y,Y,2'd3, Y,2'd2,32'h7000,4'b0000,Y);
    add(Y,N,2'd0,32'h0,   Y,N,2'd0, N,2'd0,32'h0,   4'b0000,Y);
    // rdy low: writes, flush and issue all ignored
    add(Y,Y,2'd0,32'h8000,N,N,2'd0, N,2'd0,32'h0,   4'b0000,Y);
    add(N,Y,2'd0,32'h8004,Y,N,2'd0, N,2'd0,32'h0,   4'b0000,Y);
    add(N,Y,2'd1,32'h8100,Y,Y,2'd0, N,2'd0,32'h0,   4'b0000,Y);
    add(N,Y,2'd0,32'h8008,Y,N,2'd0, N,2'd0,32'h0,   4'b0000,Y);
    add(Y,N,2'd0,32'h0,   N,N,2'd0, Y,2'd0,32'h8000,4'b0000,Y);
    add(Y,N,2'd0,32'h0,   Y,N,2'd0, Y,2'd0,32'h8000,4'b0000,Y);
    add(Y,N,2'd0,32'h0,   Y,N,2'd0, N,2'd0,32'h0,   4'b0000,Y);

    // reset state while rst is held
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_idle("reset", N);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].wv, vecs[i].ww, vecs[i].wpc, vecs[i].rd, vecs[i].fv, vecs[i].fw);
      #1;
      chk($sformatf("row%0d valid", i), {31'd0, iss_if.valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) begin
        chk($sformatf("row%0d warp", i), {30'd0, iss_if.warp_num}, {30'd0, vecs[i].ew});
        chk($sformatf("row%0d pc", i), iss_if.pc, vecs[i].epc);
        chk($sformatf("row%0d mask", i), {24'd0, iss_if.thread_mask}, {24'd0, mask_of(vecs[i].epc)});
        chk($sformatf("row%0d inst", i), iss_if.inst, inst_of(vecs[i].epc));
      end
      chk($sformatf("row%0d stall", i), {28'd0, warp_stall}, {28'd0, vecs[i].es});
      chk($sformatf("row%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].eo});
      @(negedge clk);
    end

    // asynchronous reset in the middle of live traffic
    drive(Y, Y, 2'd2, 32'h9000, N, N, 2'd0);
    @(negedge clk);
    drive(Y, Y, 2'd2, 32'h9004, N, N, 2'd0);
    @(negedge clk);
    drive(Y, N, 2'd0, 32'h0, N, N, 2'd0);
    #1;
    chk("pre_rst valid", {31'd0, iss_if.valid}, 32'd1);
    chk("pre_rst pc", iss_if.pc, 32'h9000);
    chk("pre_rst stall", {28'd0, warp_stall}, 32'h4);
    chk("pre_rst overflow", {31'd0, overflow}, 32'd1);
    drive(Y, Y, 2'd0, 32'h9100, Y, N, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst", N);
    @(negedge clk);
    chk_idle("rst_held", N);
    drive(Y, N, 2'd0, 32'h0, Y, N, 2'd0);
    rst = 1'b0;
    #1;
    chk_idle("rst_release", N);
    @(negedge clk);
    #1;
    chk_idle("post_rst", N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gelato_inst_buffer.md
# gelato_inst_buffer

Per-warp instruction buffer between the instruction decode stage and the issue/scoreboard stage. It holds decoded instructions in one small FIFO per warp and presents one instruction per cycle to issue, chosen round-robin across non-empty warps. It also gives the fetch scheduler back-pressure per warp and flushes wrong-path instructions when a warp is redirected.

## Interface
Parameters:
- NUM_WARPS, default 4: number of warps; one FIFO each.
- DEPTH, default 4: entries per warp FIFO; power of two, at least 4.
- RESERVE, default 2: slots kept free for instructions already in fetch/decode.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global enable; when low, all state holds.
- inst_decoded_data  gelato_idecode_ibuffer_if.slave  fields valid, pc[31:0], warp_num[$clog2(NUM_WARPS)-1:0], thread_mask[NUM_THREADS-1:0], inst (inst_t).
- issue_data  gelato_ibuffer_issue_if.master  fields valid (out), ready (in), pc, warp_num, thread_mask, inst (out).
- flush_valid  in  1  redirect of a warp.
- flush_warp  in  $clog2(NUM_WARPS)  warp to flush.
- warp_stall  out  NUM_WARPS  per-warp fetch back-pressure.
- overflow  out  1  sticky error flag.

## Operation
- Per warp: storage of DEPTH entries {pc, thread_mask, inst}, plus a read pointer, a write pointer ($clog2(DEPTH) bits, wrapping naturally) and a count ($clog2(DEPTH+1) bits).
- Write: when rdy and inst_decoded_data.valid, the entry goes to the FIFO selected by warp_num.
- Selection: rr_ptr resets to 0. The selected warp is the first non-empty warp w at or after rr_ptr, in order (rr_ptr + k) mod NUM_WARPS.
- issue_data.valid = rdy and some warp is non-empty and the selected warp is not being flushed this cycle. Payload is the selected warp's head entry.
- Issue: valid and ready. Pop the head and set rr_ptr to (selected + 1) mod NUM_WARPS. rr_ptr is unchanged when nothing is issued.
- Flush: when rdy and flush_valid, the flushed warp's count and both pointers go to 0. A write to the same warp in that cycle is discarded as wrong-path. Flush has priority over write and issue.
- Same warp written and issued in one cycle: both happen and count is unchanged. This is allowed even when count == DEPTH.
- Write to a full warp with no issue from that warp in the same cycle: the write is dropped and overflow is set to 1. overflow clears only on reset.
- warp_stall[w] = (count[w] >= DEPTH - RESERVE). This is combinational from registered count.
- Reset values: all counts and pointers 0, rr_ptr 0, overflow 0, issue_data.valid 0, warp_stall all 0. Storage contents are not reset.

## Timing
- Write at edge N makes the entry eligible for issue from cycle N+1. There is no empty-bypass path.
- issue_data.valid and its payload are combinational from registered state, plus the flush_valid/flush_warp mask.
- warp_stall reflects a write or issue one cycle after the edge that performed it.
- Throughput: one write and one issue per cycle.
- When rdy is low, issue_data.valid = 0 and every register holds, including flush and write effects, which are ignored that cycle.
- Reset asserted mid-operation empties all FIFOs immediately; in-flight issue_data.valid drops asynchronously.

## Structure
- gelato_types gets gelato_ibuffer_entry_t {pc, thread_mask, inst} and the parameter defaults NUM_WARPS_DEFAULT and IBUF_DEPTH_DEFAULT.
- gelato_ibuffer_issue_if is declared next to the existing stage interfaces.
- One sub-module, gelato_warp_fifo, is instantiated NUM_WARPS times. It has ports push, pop, flush, the entry, count and empty.
- The top level holds the round-robin arbiter, the flush/write/issue steering and the overflow flag.

## Test plan
- Reset, then write warp 2 at PC 0x100 with ready = 1. issue_data.valid rises one cycle later with warp_num 2 and pc 0x100. Count returns to 0 after the issue.
- Hold ready = 0 and write four instructions to each of warps 0, 1 and 3. Then set ready = 1. Issue order is warps 0, 1, 3, 0, 1, 3, …, with each warp's PCs in FIFO order.
- With DEPTH = 4 and RESERVE = 2, write two entries to warp 1: warp_stall[1] = 1. Write two more: the FIFO is full and overflow = 0. Write a fifth with ready = 0: it is dropped and overflow latches to 1.
- Warp 0 holds 3 entries. Assert flush_valid with flush_warp = 0 together with a write to warp 0 and ready = 1. issue_data.valid = 0 that cycle; afterwards count[0] = 0 and the written entry is absent.
- Warp 1 is full. Issue from warp 1 and write to warp 1 in the same cycle. Both succeed, count stays 4 and overflow stays 0.
- Hold rdy = 0 for 3 cycles with valid writes and ready = 1. No state changes and issue_data.valid = 0. Then assert rst asynchronously mid-stream: every output returns to its reset value immediately.
